// File: rtl/gpu_mem_pkg.sv
// gpu_mem_pkg
// Shared constants and types for the GPU memory-side blocks.
//   VRAM_W / VRAM_H : VRAM dimensions in pixels (one 16-bit halfword per pixel)
//   VRAM_AW         : width of a VRAM halfword address (Y*VRAM_W + X)
//   state_e         : states of the CPU-to-VRAM rectangle writer
package gpu_mem_pkg;

    localparam int VRAM_W  = 1024;
    localparam int VRAM_H  = 512;
    localparam int VRAM_AW = 19;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT_ACK,
        DONE
    } state_e;

endpackage

// File: rtl/gpu_vram_rect_walker.sv
// gpu_vram_rect_walker
// Walks a destination rectangle in raster order and presents the current
// destination pixel coordinate, wrapped to the VRAM dimensions.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   load_i         : latch origin/size and restart at the top-left pixel
//   x_i,y_i,w_i,h_i: rectangle origin and size
//   adv_i, adv2_i  : advance the walk by one pixel (adv2_i=0) or two (adv2_i=1)
//   px_o, py_o     : current destination X / Y
//   pair_ok_o      : a two-pixel write may start at the current pixel
//   last_o         : advancing by the requested step finishes the rectangle
module gpu_vram_rect_walker
    import gpu_mem_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [9:0]  x_i,
    input  logic [8:0]  y_i,
    input  logic [10:0] w_i,
    input  logic [9:0]  h_i,
    input  logic        adv_i,
    input  logic        adv2_i,
    output logic [9:0]  px_o,
    output logic [8:0]  py_o,
    output logic        pair_ok_o,
    output logic        last_o
);

    logic [9:0]  x0_q;
    logic [8:0]  y0_q;
    logic [10:0] w_q;
    logic [9:0]  h_q;
    logic [10:0] cx_q, cx_d;
    logic [9:0]  cy_q, cy_d;

    logic [10:0] xSum;
    logic [10:0] cxStep;
    logic        rowEnd;
    logic        wrapped;

    // cx never exceeds 1023 while a pixel is pending, so the 11-bit sum
    // shows directly whether this row has already crossed X=1023->0.
    assign xSum    = {1'b0, x0_q} + cx_q;
    assign wrapped = (xSum >= 11'(VRAM_W));
    assign px_o    = xSum[9:0];
    assign py_o    = y0_q + cy_q[8:0];

    // Past the horizontal wrap only single writes are used.
    assign pair_ok_o = ~px_o[0] && ((w_q - cx_q) >= 11'd2) && ~wrapped;

    assign cxStep = cx_q + (adv2_i ? 11'd2 : 11'd1);
    assign rowEnd = (cxStep == w_q);
    assign last_o = rowEnd && ((cy_q + 10'd1) == h_q);

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (load_i) begin
            cx_d = '0;
            cy_d = '0;
        end else if (adv_i) begin
            if (rowEnd) begin
                cx_d = '0;
                cy_d = cy_q + 10'd1;
            end else begin
                cx_d = cxStep;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x0_q <= '0;
            y0_q <= '0;
            w_q  <= '0;
            h_q  <= '0;
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            if (load_i) begin
                x0_q <= x_i;
                y0_q <= y_i;
                w_q  <= w_i;
                h_q  <= h_i;
            end
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

endmodule

// File: rtl/gpu_mem_cpuvram_writer.sv
// gpu_mem_cpuvram_writer
// Copies pixels from a CPU-side pixel FIFO into a VRAM rectangle, one or two
// pixels (one 32-bit word) per VRAM write request.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   start_i               : begin a copy (ignored while busy_o)
//   x_i,y_i,w_i,h_i       : destination origin and size, sampled on start
//   force_mask_i          : force bit 15 of every written pixel, sampled on start
//   abort_i               : cancel the copy (after the outstanding write is acked)
//   busy_o, done_o        : copy in progress / one-cycle completion pulse
//   valid0_i,data0_i      : FIFO head;  valid1_i,data1_i : FIFO head+1
//   pop0_o, pop1_o        : consume head / head+1 (combinational)
//   fifo_flush_o          : one-cycle FIFO flush after an abort
//   mem_req_o..mem_be_o   : registered VRAM write request, held until mem_ack_i
module gpu_mem_cpuvram_writer #(
    parameter int VRAM_AW = gpu_mem_pkg::VRAM_AW
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [9:0]         x_i,
    input  logic [8:0]         y_i,
    input  logic [10:0]        w_i,
    input  logic [9:0]         h_i,
    input  logic               force_mask_i,
    input  logic               abort_i,
    output logic               busy_o,
    output logic               done_o,
    input  logic               valid0_i,
    input  logic [15:0]        data0_i,
    input  logic               valid1_i,
    input  logic [15:0]        data1_i,
    output logic               pop0_o,
    output logic               pop1_o,
    output logic               fifo_flush_o,
    output logic               mem_req_o,
    output logic [VRAM_AW-1:0] mem_addr_o,
    output logic [31:0]        mem_data_o,
    output logic [1:0]         mem_be_o,
    input  logic               mem_ack_i
);

    import gpu_mem_pkg::*;

    state_e state_q, state_d;

    logic               loadParams;
    logic               ackHere;
    logic               abortExit;
    logic               issuePair;
    logic               force_q;
    logic               abortPend_q;
    logic               flush_q;
    logic               mem_req_q;
    logic [VRAM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]        mem_data_q, mem_data_d;
    logic [1:0]         mem_be_q, mem_be_d;
    logic [15:0]        pix0, pix1;

    logic [9:0]         px;
    logic [8:0]         py;
    logic               pairOk;
    logic               lastPix;

    assign loadParams = (state_q == IDLE) && start_i;
    assign ackHere    = (state_q == WAIT_ACK) && mem_ack_i;
    // An abort seen while a write is outstanding is only acted on once that
    // write has been accepted, so the memory side never sees a dropped request.
    assign abortExit  = ((state_q == RUN) && abort_i) ||
                        (ackHere && (abortPend_q || abort_i));

    gpu_vram_rect_walker u_walker (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (loadParams),
        .x_i       (x_i),
        .y_i       (y_i),
        .w_i       (w_i),
        .h_i       (h_i),
        .adv_i     (ackHere),
        .adv2_i    (mem_be_q == 2'b11),
        .px_o      (px),
        .py_o      (py),
        .pair_ok_o (pairOk),
        .last_o    (lastPix)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = ((w_i == 11'd0) || (h_i == 10'd0)) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (pop0_o) begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (mem_ack_i) begin
                    if (abortPend_q || abort_i) begin
                        state_d = IDLE;
                    end else if (lastPix) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy_o    = (state_q != IDLE);
        done_o    = (state_q == DONE);
        issuePair = 1'b0;
        pop0_o    = 1'b0;
        pop1_o    = 1'b0;
        if ((state_q == RUN) && !abort_i && valid0_i) begin
            issuePair = pairOk && valid1_i;
            pop0_o    = 1'b1;
            pop1_o    = issuePair;
        end
    end

    // Request word: low pixel sits in bits 15:0 at the even halfword address.
    always_comb begin
        pix0       = force_q ? {1'b1, data0_i[14:0]} : data0_i;
        pix1       = force_q ? {1'b1, data1_i[14:0]} : data1_i;
        mem_addr_d = VRAM_AW'({py, px[9:1], 1'b0});
        if (issuePair) begin
            mem_data_d = {pix1, pix0};
            mem_be_d   = 2'b11;
        end else if (px[0]) begin
            mem_data_d = {pix0, 16'h0000};
            mem_be_d   = 2'b10;
        end else begin
            mem_data_d = {16'h0000, pix0};
            mem_be_d   = 2'b01;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            force_q     <= 1'b0;
            abortPend_q <= 1'b0;
            flush_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_be_q    <= '0;
        end else begin
            if (loadParams) begin
                force_q <= force_mask_i;
            end
            abortPend_q <= (state_q == WAIT_ACK) && !mem_ack_i && (abortPend_q || abort_i);
            flush_q     <= abortExit;
            if (pop0_o) begin
                mem_req_q  <= 1'b1;
                mem_addr_q <= mem_addr_d;
                mem_data_q <= mem_data_d;
                mem_be_q   <= mem_be_d;
            end else if (ackHere) begin
                mem_req_q <= 1'b0;
            end
        end
    end

    assign fifo_flush_o = flush_q;
    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign mem_be_o     = mem_be_q;

endmodule

// File: tb/tb_gpu_mem_cpuvram_writer.sv
// tb_gpu_mem_cpuvram_writer
// Drives rectangle copies from a modelled pixel FIFO and compares every cycle
// against a pixel-index reference: pixel k of a copy lands at
// ((x + k%w) mod 1024, (y + k/w) mod 512), grouped into one- or two-pixel writes.
module tb_gpu_mem_cpuvram_writer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [9:0]  x_i;
    logic [8:0]  y_i;
    logic [10:0] w_i;
    logic [9:0]  h_i;
    logic        force_mask_i;
    logic        abort_i;
    logic        busy_o;
    logic        done_o;
    logic        valid0_i;
    logic [15:0] data0_i;
    logic        valid1_i;
    logic [15:0] data1_i;
    logic        pop0_o;
    logic        pop1_o;
    logic        fifo_flush_o;
    logic        mem_req_o;
    logic [18:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [1:0]  mem_be_o;
    logic        mem_ack_i;

    int errors = 0;
    int checks = 0;
    logic [15:0] pixQ[$];

    always #5 clk_i = ~clk_i;

    gpu_mem_cpuvram_writer #(.VRAM_AW(19)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .x_i          (x_i),
        .y_i          (y_i),
        .w_i          (w_i),
        .h_i          (h_i),
        .force_mask_i (force_mask_i),
        .abort_i      (abort_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .valid0_i     (valid0_i),
        .data0_i      (data0_i),
        .valid1_i     (valid1_i),
        .data1_i      (data1_i),
        .pop0_o       (pop0_o),
        .pop1_o       (pop1_o),
        .fifo_flush_o (fifo_flush_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_be_o     (mem_be_o),
        .mem_ack_i    (mem_ack_i)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy_o), 32'd0);
        checkOutput({tag, "_done"}, 32'(done_o), 32'd0);
        checkOutput({tag, "_req"}, 32'(mem_req_o), 32'd0);
        checkOutput({tag, "_pop0"}, 32'(pop0_o), 32'd0);
        checkOutput({tag, "_pop1"}, 32'(pop1_o), 32'd0);
        checkOutput({tag, "_flush"}, 32'(fifo_flush_o), 32'd0);
        checkOutput({tag, "_be"}, 32'(mem_be_o), 32'd0);
        checkOutput({tag, "_addr"}, 32'(mem_addr_o), 32'd0);
        checkOutput({tag, "_data"}, mem_data_o, 32'd0);
    endtask

    // abortMode: 0 none (random abort in the done cycle, must be ignored),
    // 1 abort in the first cycle of write group abortGroup's wait,
    // 2 abort while able to issue group abortGroup.
    // ackDelay < 0 picks a random 0..3 cycle ack delay per write.
    task automatic applyStimulus(input int x, input int y, input int w, input int h,
                                 input bit mask, input int abortMode, input int abortGroup,
                                 input int ackDelay, input bit gateValid, input bit toggleV1,
                                 input bit spurStart);
        int total, k, groupIdx, pendCnt, delay, n, cx, cy, px, py;
        bit active, canIssue, pend, doneExp, flushExp, abortLatched, finished;
        bit nActive, nCan, nPend, nDone, nFlush;
        bit v0, v1, popExp, pairExp;
        logic [18:0] eAddr;
        logic [1:0]  eBe;
        logic [31:0] eData;
        logic [15:0] m0, m1;

        total = w * h;
        pixQ.delete();
        for (int i = 0; i < total + 4; i++) pixQ.push_back(16'($urandom));
        delay = 0;
        eAddr = '0;
        eBe   = '0;
        eData = '0;

        @(negedge clk_i);
        start_i      = 1'b1;
        x_i          = 10'(x);
        y_i          = 9'(y);
        w_i          = 11'(w);
        h_i          = 10'(h);
        force_mask_i = mask;
        abort_i      = 1'b0;
        mem_ack_i    = 1'b0;
        valid0_i     = 1'b1;
        valid1_i     = 1'b1;
        data0_i      = pixQ[0];
        data1_i      = pixQ[1];
        #1;
        checkOutput("startBusy", 32'(busy_o), 32'd0);
        checkOutput("startPop", 32'(pop0_o), 32'd0);
        @(posedge clk_i);

        active = 1'b1;
        canIssue = (total > 0);
        doneExp = (total == 0);
        pend = 1'b0;
        flushExp = 1'b0;
        abortLatched = 1'b0;
        finished = 1'b0;
        k = 0;
        groupIdx = 0;
        pendCnt = 0;

        for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
            @(negedge clk_i);
            start_i = spurStart && active && ($urandom_range(0, 4) == 0);
            x_i = 10'($urandom);
            y_i = 9'($urandom);
            w_i = 11'($urandom_range(1, 1024));
            h_i = 10'($urandom_range(1, 512));
            force_mask_i = 1'($urandom_range(0, 1));
            v0 = (pixQ.size() > 0) && (!gateValid || ($urandom_range(0, 3) != 0));
            v1 = (pixQ.size() > 1) && (!toggleV1 || ($urandom_range(0, 1) == 1));
            valid0_i = v0;
            valid1_i = v1;
            data0_i  = (pixQ.size() > 0) ? pixQ[0] : 16'($urandom);
            data1_i  = (pixQ.size() > 1) ? pixQ[1] : 16'($urandom);
            case (abortMode)
                1: abort_i = pend && (pendCnt == 0) && ((groupIdx - 1) == abortGroup);
                2: abort_i = canIssue && (groupIdx == abortGroup);
                default: abort_i = doneExp && ($urandom_range(0, 1) == 1);
            endcase
            mem_ack_i = pend && (pendCnt >= delay);
            #1;

            popExp  = canIssue && v0 && !abort_i;
            pairExp = 1'b0;
            px = 0;
            if (popExp) begin
                cx = k % w;
                px = (x + cx) % 1024;
                pairExp = v1 && (px % 2 == 0) && (w - cx >= 2) && (x + cx < 1024);
            end
            checkOutput("pop0", 32'(pop0_o), 32'(popExp));
            checkOutput("pop1", 32'(pop1_o), 32'(pairExp));
            checkOutput("req", 32'(mem_req_o), 32'(pend));
            checkOutput("busy", 32'(busy_o), 32'(active));
            checkOutput("done", 32'(done_o), 32'(doneExp));
            checkOutput("flush", 32'(fifo_flush_o), 32'(flushExp));
            if (pend) begin
                checkOutput("addr", 32'(mem_addr_o), 32'(eAddr));
                checkOutput("be", 32'(mem_be_o), 32'(eBe));
                checkOutput("data", mem_data_o, eData);
            end

            nActive = active;
            nCan    = canIssue;
            nPend   = pend;
            nDone   = 1'b0;
            nFlush  = 1'b0;
            if (!active) finished = 1'b1;
            if (doneExp) nActive = 1'b0;
            if (popExp) begin
                n  = pairExp ? 2 : 1;
                cy = k / w;
                py = (y + cy) % 512;
                m0 = pixQ[0] | (mask ? 16'h8000 : 16'h0000);
                m1 = pairExp ? (pixQ[1] | (mask ? 16'h8000 : 16'h0000)) : 16'h0000;
                eAddr = 19'(py * 1024 + px - (px % 2));
                if (n == 2) begin
                    eBe = 2'b11;
                    eData = {m1, m0};
                end else if (px % 2 == 1) begin
                    eBe = 2'b10;
                    eData = {m0, 16'h0000};
                end else begin
                    eBe = 2'b01;
                    eData = {16'h0000, m0};
                end
                for (int i = 0; i < n; i++) void'(pixQ.pop_front());
                k += n;
                groupIdx++;
                nPend = 1'b1;
                nCan = 1'b0;
                pendCnt = 0;
                abortLatched = 1'b0;
                delay = (ackDelay >= 0) ? ackDelay : int'($urandom_range(0, 3));
            end
            if (canIssue && abort_i) begin
                nCan = 1'b0;
                nActive = 1'b0;
                nFlush = 1'b1;
            end
            if (pend) begin
                if (abort_i) abortLatched = 1'b1;
                if (mem_ack_i) begin
                    nPend = 1'b0;
                    if (abortLatched) begin
                        nActive = 1'b0;
                        nFlush = 1'b1;
                    end else if (k == total) begin
                        nDone = 1'b1;
                    end else begin
                        nCan = 1'b1;
                    end
                end else begin
                    pendCnt++;
                end
            end
            if (nFlush) pixQ.delete();
            active   = nActive;
            canIssue = nCan;
            pend     = nPend;
            doneExp  = nDone;
            flushExp = nFlush;
        end
        if (!finished) checkOutput("timeout", 32'd0, 32'd1);
        start_i   = 1'b0;
        abort_i   = 1'b0;
        mem_ack_i = 1'b0;
    endtask

    // Reset asserted while a write request is outstanding.
    task automatic resetMidCopy();
        @(negedge clk_i);
        start_i = 1'b1;
        x_i = 10'd3;
        y_i = 9'd4;
        w_i = 11'd8;
        h_i = 10'd1;
        force_mask_i = 1'b0;
        abort_i = 1'b0;
        mem_ack_i = 1'b0;
        valid0_i = 1'b1;
        valid1_i = 1'b1;
        data0_i = 16'h1234;
        data1_i = 16'h5678;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        #1;
        checkOutput("rstPreReq", 32'(mem_req_o), 32'd1);
        checkOutput("rstPreBusy", 32'(busy_o), 32'd1);
        #1;
        rst_i = 1'b1;
        #1;
        checkAllZero("midRst");
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        start_i = 1'b0;
        x_i = '0;
        y_i = '0;
        w_i = '0;
        h_i = '0;
        force_mask_i = 1'b0;
        abort_i = 1'b0;
        valid0_i = 1'b0;
        valid1_i = 1'b0;
        data0_i = '0;
        data1_i = '0;
        mem_ack_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        checkAllZero("reset");
        @(negedge clk_i);
        rst_i = 1'b0;

        $display("[TB] basic pair copy");
        applyStimulus(0, 0, 4, 1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        $display("[TB] odd origin with forced mask");
        applyStimulus(1, 10, 3, 2, 1'b1, 0, 0, 1, 1'b0, 1'b0, 1'b0);
        $display("[TB] horizontal and vertical wrap");
        applyStimulus(1022, 511, 4, 2, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        $display("[TB] slow ack with toggling valid1");
        applyStimulus(100, 200, 9, 3, 1'b0, 0, 0, 5, 1'b0, 1'b1, 1'b0);
        $display("[TB] abort while waiting for ack");
        applyStimulus(7, 3, 6, 2, 1'b0, 1, 1, 3, 1'b0, 1'b0, 1'b0);
        $display("[TB] zero-size starts");
        applyStimulus(5, 5, 0, 3, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(5, 5, 7, 0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        $display("[TB] abort while running");
        applyStimulus(20, 30, 10, 2, 1'b0, 2, 2, -1, 1'b1, 1'b1, 1'b0);
        $display("[TB] randomized copies");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
                          int'($urandom_range(1, 24)), int'($urandom_range(1, 4)),
                          1'($urandom_range(0, 1)), 0, 0, -1, 1'b1, 1'b1, 1'b1);
        end
        $display("[TB] full-width rows");
        applyStimulus(5, 300, 1024, 2, 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        $display("[TB] reset mid-copy then restart");
        resetMidCopy();
        applyStimulus(1021, 100, 5, 3, 1'b0, 0, 0, -1, 1'b1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
